// File: rtl/mem_access_ctrl.sv
// Load/store front end for the 32 x 32-bit data RAM: byte/half/word access,
// alignment checking, load extension and read-modify-write for sub-word stores.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_data,
  output logic [4:0]  ram_addr,
  output logic        ram_wr,
  output logic        ram_enable,
  input  logic [31:0] ram_q
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // ACCESS | RAM word addressed; word store written, load/RMW read captured
  // WRITE  | merged sub-word store written back
  // RESP   | response held until resp_ready
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_bad_req;
  logic        w_word_store;
  logic        w_ram_write;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_bad_req = (req_size == 2'b11) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign w_word_store = r_we && (r_size == SZ_WORD);

  // Gated by rst so a write in flight never lands at the next edge.
  assign w_ram_write = !rst && (((r_state == S_ACCESS) && w_word_store) ||
                                (r_state == S_WRITE));

  always_comb begin
    w_byte = ram_q[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = ram_q[7:0];
      2'd1: w_byte = ram_q[15:8];
      2'd2: w_byte = ram_q[23:16];
      2'd3: w_byte = ram_q[31:24];
      default: w_byte = ram_q[7:0];
    endcase
  end

  assign w_half = r_addr[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    w_load = ram_q;
    case (r_size)
      SZ_BYTE: w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = ram_q;
    endcase
  end

  always_comb begin
    w_merged = ram_q;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = ram_q;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 7'd0;
      r_wdata    <= 32'd0;
      r_merged   <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= 32'd0;
            r_err      <= w_bad_req;
            r_state    <= w_bad_req ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end else if (w_word_store) begin
            r_state <= S_RESP;
          end else begin
            r_merged <= w_merged;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = !rst && (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign ram_addr   = r_addr[6:2];
  assign ram_enable = w_ram_write;
  assign ram_wr     = w_ram_write;
  assign ram_data   = (r_state == S_WRITE) ? r_merged :
                      (((r_state == S_ACCESS) && w_word_store) ? r_wdata : 32'd0);

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store front end that sits directly upstream of the 32-word × 32-bit data RAM and is its only driver. Accepts byte-addressed load/store requests from the CPU datapath over a valid/ready handshake, performs byte/halfword/word access with alignment checking, and sign/zero extension. Sub-word stores use read-modify-write. Returns a held response until the CPU takes it.

## Interface
Parameters:
- none; geometry fixed at 32 words × 32 bits, 7-bit byte address (128 bytes).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  7  byte address; [6:2] word index, [1:0] byte offset.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response held until taken.
- resp_ready  in  1  CPU accepts response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- ram_data  out  32  RAM write data.
- ram_addr  out  5  RAM word address.
- ram_wr  out  1  RAM write select (1 write, 0 read).
- ram_enable  out  1  RAM enable.
- ram_q  in  32  RAM read data, combinational from ram_addr.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata at the edge.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size=11 → RESP with err=1, no RAM write.
  - Otherwise → ACCESS.
- ACCESS: ram_addr = latched addr[6:2].
  - Word store: ram_enable=1, ram_wr=1, ram_data=wdata. → RESP.
  - Load: ram_enable=0. Capture ram_q, select lane, extend into resp_rdata. → RESP.
  - Sub-word store: ram_enable=0. Capture ram_q and merge wdata into the addressed lane(s) (little-endian: byte lane = addr[1:0], half lane = addr[1]). → WRITE.
- WRITE: ram_enable=1, ram_wr=1, ram_data=merged word. → RESP.
- RESP: resp_valid=1, with rdata and err stable. When resp_ready=1 at the edge → IDLE.
- Lane extraction:
  - Byte = q[8·off+7 : 8·off].
  - Half = q[16·addr[1]+15 : 16·addr[1]].
  - Sign bit is the lane MSB.
- ram_enable and ram_wr are 0 in every state other than the write cycles listed above. At most one RAM write per request.

## Timing
- Reset values: state IDLE, req_ready=1 (0 while rst is high), resp_valid=0, resp_rdata=0, resp_err=0, ram_enable=0, ram_wr=0, ram_addr=0, ram_data=0.
- Accept at edge E0. Latency to resp_valid:
  - Load: resp_valid from E2.
  - Word store: RAM written at E2, resp_valid from E2.
  - Sub-word store: read in cycle E1–E2, written at E3, resp_valid from E3.
  - Error: resp_valid from E1.
- Throughput: back-to-back requests accepted only after the RESP handshake. The earliest next accept is the edge after resp_ready is sampled high.
- resp_ready low holds RESP indefinitely with outputs unchanged.
- req_valid while not in IDLE is ignored; the request is not consumed because req_ready=0.
- rst asserted mid-operation:
  - ram_enable and ram_wr drop immediately (combinational clear), so no write occurs at the next edge.
  - Any pending response is discarded.
  - RAM contents are untouched.
- Read-modify-write is atomic: no other agent drives the RAM.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load addr 0x10 → resp_rdata=0xDEADBEEF, err=0; store resp at E2, load resp at E2.
- Byte store 0x7F to addr 0x11 over 0xDEADBEEF → word at 0x10 reads 0xDEAD7FEF. Byte load 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE.
- Half store 0x1234 to addr 0x22 over 0xAAAABBBB → 0x1234BBBB. Half load 0x22 signed of 0x8001 → 0xFFFF8001. Verify ram_wr pulses exactly once, at E3.
- Misaligned word load addr 0x05, half store addr 0x03, size=11 → resp_err=1, rdata=0, resp_valid at E1, no RAM write.
- Hold resp_ready=0 for 5 cycles → resp_valid and rdata stable, req_ready=0, a new req_valid is not accepted. Release → IDLE next edge.
- Assert rst during the WRITE state of a byte store → ram_wr=0 immediately, target word unchanged, outputs at reset values, req_ready=1 after release.
